// File: rtl/pvtmon_poll_scheduler.sv
// PMBus READ_WORD poll sequencer: walks a (device, command) table through a byte-level
// I2C master and packs each result into one 32-bit power_status word.
module pvtmon_poll_scheduler #(
  parameter int unsigned                   NUM_POWER_REG  = 13,
  parameter int unsigned                   POLL_DIV       = 1000000,
  parameter int unsigned                   RSP_TIMEOUT    = 65535,
  parameter logic [NUM_POWER_REG*7-1:0]    DEV_ADDR_TABLE = {NUM_POWER_REG{7'h40}},
  parameter logic [NUM_POWER_REG*8-1:0]    CMD_TABLE      = {NUM_POWER_REG{8'h8B}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          i2c_cmd_valid,
  input  logic                          i2c_cmd_ready,
  output logic [1:0]                    i2c_cmd_op,
  output logic [7:0]                    i2c_cmd_wdata,
  output logic                          i2c_cmd_nack,
  input  logic                          i2c_rsp_valid,
  input  logic [7:0]                    i2c_rsp_data,
  input  logic                          i2c_rsp_nack,
  output logic [NUM_POWER_REG*32-1:0]   power_status,
  output logic                          round_done,
  output logic                          busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_START1, S_WADDR, S_WCMD, S_START2,
    S_RADDR, S_RLSB, S_RMSB, S_STOP, S_NEXT
  } state_t;

  localparam logic [1:0]  OP_START  = 2'b00;
  localparam logic [1:0]  OP_STOP   = 2'b01;
  localparam logic [1:0]  OP_WRITE  = 2'b10;
  localparam logic [1:0]  OP_READ   = 2'b11;
  localparam int unsigned IW        = (NUM_POWER_REG > 1) ? $clog2(NUM_POWER_REG) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_POWER_REG - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_DIV - 1);
  localparam logic [31:0] TO_LAST   = 32'(RSP_TIMEOUT - 1);

  state_t        state, state_nxt, follow;
  logic [IW-1:0] idx;
  logic          pending;
  logic [31:0]   to_cnt;
  logic [31:0]   period_cnt;
  logic          err_seen;
  logic [7:0]    lsb_q, msb_q;
  logic [31:0]   status_q [NUM_POWER_REG];

  logic [6:0]    dev_addr;
  logic [7:0]    cmd_code;
  logic          is_cmd;
  logic          timeout, rsp_done, rsp_fail;
  logic          round_start, last_entry;
  logic [31:0]   cur_word;
  logic [5:0]    err_cnt_inc;

  assign dev_addr    = DEV_ADDR_TABLE[idx*7 +: 7];
  assign cmd_code    = CMD_TABLE[idx*8 +: 8];
  assign last_entry  = (idx == LAST_IDX);
  assign cur_word    = status_q[idx];
  assign err_cnt_inc = (cur_word[29:24] == 6'h3F) ? 6'h3F : cur_word[29:24] + 6'd1;

  // A response on the same cycle the budget runs out wins over the timeout.
  assign timeout     = pending & ~i2c_rsp_valid & (to_cnt >= TO_LAST);
  assign rsp_done    = pending & (i2c_rsp_valid | timeout);
  assign rsp_fail    = pending & ((i2c_rsp_valid & i2c_rsp_nack) | timeout);
  assign round_start = enable & ((state == S_IDLE) |
                                 ((state == S_WAIT) & (period_cnt >= POLL_LAST)));

  assign i2c_cmd_valid = is_cmd & ~pending;
  assign round_done    = (state == S_NEXT) & last_entry;
  assign busy          = (state != S_IDLE) & (state != S_WAIT);

  always_comb begin
    power_status = '0;
    for (int unsigned i = 0; i < NUM_POWER_REG; i++)
      power_status[i*32 +: 32] = status_q[i];
  end

  always_comb begin
    state_nxt     = state;
    follow        = S_STOP;
    is_cmd        = 1'b1;
    i2c_cmd_op    = OP_START;
    i2c_cmd_wdata = '0;
    i2c_cmd_nack  = 1'b0;
    case (state)
      S_START1: follow = S_WADDR;
      S_WADDR: begin
        i2c_cmd_op    = OP_WRITE;
        i2c_cmd_wdata = {dev_addr, 1'b0};
        follow        = S_WCMD;
      end
      S_WCMD: begin
        i2c_cmd_op    = OP_WRITE;
        i2c_cmd_wdata = cmd_code;
        follow        = S_START2;
      end
      S_START2: follow = S_RADDR;
      S_RADDR: begin
        i2c_cmd_op    = OP_WRITE;
        i2c_cmd_wdata = {dev_addr, 1'b1};
        follow        = S_RLSB;
      end
      S_RLSB: begin
        i2c_cmd_op = OP_READ;
        follow     = S_RMSB;
      end
      S_RMSB: begin
        i2c_cmd_op   = OP_READ;
        i2c_cmd_nack = 1'b1;
        follow       = S_STOP;
      end
      S_STOP: begin
        i2c_cmd_op = OP_STOP;
        follow     = S_NEXT;
      end
      default: is_cmd = 1'b0;
    endcase

    case (state)
      S_IDLE, S_WAIT: if (round_start) state_nxt = S_START1;
      S_NEXT:         state_nxt = last_entry ? S_WAIT : S_START1;
      S_STOP:         if (rsp_done) state_nxt = S_NEXT;
      default:        if (rsp_done) state_nxt = rsp_fail ? S_STOP : follow;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      to_cnt     <= '0;
      period_cnt <= '0;
      err_seen   <= 1'b0;
      lsb_q      <= '0;
      msb_q      <= '0;
      for (int unsigned i = 0; i < NUM_POWER_REG; i++)
        status_q[i] <= '0;
    end else begin
      state <= state_nxt;

      // Saturating at the threshold is indistinguishable from free-running for the start test.
      if (round_start)
        period_cnt <= '0;
      else if (period_cnt < POLL_LAST)
        period_cnt <= period_cnt + 32'd1;

      if (i2c_cmd_valid && i2c_cmd_ready) begin
        pending <= 1'b1;
        to_cnt  <= '0;
      end else if (rsp_done) begin
        pending <= 1'b0;
      end else if (pending) begin
        to_cnt  <= to_cnt + 32'd1;
      end

      if (rsp_done && !rsp_fail && state == S_RLSB) lsb_q <= i2c_rsp_data;
      if (rsp_done && !rsp_fail && state == S_RMSB) msb_q <= i2c_rsp_data;
      if (rsp_fail && state != S_STOP) err_seen <= 1'b1;

      if (state == S_STOP && rsp_done) begin
        err_seen <= 1'b0;
        if (err_seen)
          status_q[idx] <= {1'b0, 1'b1, err_cnt_inc, cur_word[23:0]};
        else
          status_q[idx] <= {1'b1, 1'b0, cur_word[29:24], cur_word[23:16] + 8'd1, msb_q, lsb_q};
      end

      if (state == S_NEXT) idx <= last_entry ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_pvtmon_poll_scheduler.sv
// Directed bench: behavioural I2C byte master model with NACK/no-response/stall knobs.
module tb_pvtmon_poll_scheduler;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          i2c_cmd_valid;
  logic          i2c_cmd_ready = 1'b1;
  logic [1:0]    i2c_cmd_op;
  logic [7:0]    i2c_cmd_wdata;
  logic          i2c_cmd_nack;
  logic          i2c_rsp_valid = 1'b0;
  logic [7:0]    i2c_rsp_data = 8'h00;
  logic          i2c_rsp_nack = 1'b0;
  logic [N*32-1:0] power_status;
  logic          round_done;
  logic          busy;

  pvtmon_poll_scheduler #(
    .NUM_POWER_REG  (N),
    .POLL_DIV       (200),
    .RSP_TIMEOUT    (50),
    .DEV_ADDR_TABLE ({N{7'h40}}),
    .CMD_TABLE      ({N{8'h8B}})
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .i2c_cmd_valid (i2c_cmd_valid),
    .i2c_cmd_ready (i2c_cmd_ready),
    .i2c_cmd_op    (i2c_cmd_op),
    .i2c_cmd_wdata (i2c_cmd_wdata),
    .i2c_cmd_nack  (i2c_cmd_nack),
    .i2c_rsp_valid (i2c_rsp_valid),
    .i2c_rsp_data  (i2c_rsp_data),
    .i2c_rsp_nack  (i2c_rsp_nack),
    .power_status  (power_status),
    .round_done    (round_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // I2C master model state
  int         cyc = 0;
  logic [10:0] log_cmd [$];
  int         log_cyc [$];
  int         dly = 0;
  logic       rsp_nack_q = 1'b0;
  logic [7:0] rsp_data_q = 8'h00;
  int         ent = 0;
  int         nack_entry = -1;
  bit         nack_all = 1'b0;
  bit         noresp = 1'b0;
  bit         hold_req = 1'b0;
  bit         holding = 1'b0;
  int         hold_left = 0;
  int         rd_cnt = 0;

  logic [10:0] exp_seq [8] = '{
    {2'b00, 8'h00, 1'b0}, {2'b10, 8'h80, 1'b0}, {2'b10, 8'h8B, 1'b0}, {2'b00, 8'h00, 1'b0},
    {2'b10, 8'h81, 1'b0}, {2'b11, 8'h00, 1'b0}, {2'b11, 8'h00, 1'b1}, {2'b01, 8'h00, 1'b0}
  };

  always @(posedge clk) cyc++;

  // Inputs change on the falling edge so the DUT sees them settled at the rising edge.
  always @(negedge clk) begin
    i2c_rsp_valid = 1'b0;
    i2c_rsp_nack  = 1'b0;
    i2c_rsp_data  = 8'h00;
    if (round_done) rd_cnt++;
    if (!hold_req) holding = 1'b0;
    if (reset) begin
      dly = 0;
      ent = 0;
      i2c_cmd_ready = 1'b1;
    end else begin
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          i2c_rsp_valid = 1'b1;
          i2c_rsp_nack  = rsp_nack_q;
          i2c_rsp_data  = rsp_data_q;
        end
      end
      i2c_cmd_ready = 1'b1;
      if (!holding && hold_req && i2c_cmd_valid && i2c_cmd_op == 2'b10 && i2c_cmd_wdata == 8'h8B) begin
        holding   = 1'b1;
        hold_left = 20;
      end
      if (holding && hold_left > 0) begin
        i2c_cmd_ready = 1'b0;
        hold_left--;
        check("hold_stable", {21'd0, i2c_cmd_valid, i2c_cmd_op, i2c_cmd_wdata},
              {21'd0, 1'b1, 2'b10, 8'h8B});
      end
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        log_cmd.push_back({i2c_cmd_op, i2c_cmd_wdata, i2c_cmd_nack});
        log_cyc.push_back(cyc);
        rsp_nack_q = (i2c_cmd_op == 2'b10) && (i2c_cmd_wdata == 8'h80) &&
                     (nack_all || ent == nack_entry);
        rsp_data_q = (i2c_cmd_op == 2'b11) ? (i2c_cmd_nack ? 8'h12 : 8'h34) : 8'h00;
        if (i2c_cmd_op == 2'b01) ent = (ent + 1) % N;
        if (!(noresp && i2c_cmd_op == 2'b11 && !i2c_cmd_nack)) dly = 2;
      end
    end
  end

  function automatic logic [31:0] word(input int i);
    return power_status[i*32 +: 32];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick(3);
    reset = 1'b0;
    log_cmd.delete();
    log_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic wait_round();
    int n = 0;
    while (!round_done && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("round_timeout", 32'(n), 32'd0);
    tick();
  endtask

  // Field-wise compare of one entry's 8-command stream: wdata only on WRITE, nack only on READ.
  task automatic chk_seq(input int base);
    logic [10:0] got, e, m;
    for (int i = 0; i < 8; i++) begin
      e = exp_seq[i];
      m = {2'b11, (e[10:9] == 2'b10) ? 8'hFF : 8'h00, e[10:9] == 2'b11};
      got = (base + i < log_cmd.size()) ? log_cmd[base + i] : 11'h7FF;
      check($sformatf("seq[%0d]", base + i), {21'd0, got & m}, {21'd0, e & m});
    end
  endtask

  initial begin
    int n;
    int seen;

    // reset state and first ideal round
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("rst_word%0d", i), word(i), 32'h0);
    check("rst_outs", {28'd0, i2c_cmd_valid, busy, round_done, i2c_cmd_op != 2'b00}, 32'h0);
    enable = 1'b1;
    tick();
    check("busy_start", {31'd0, busy}, 32'd1);
    wait_round();
    for (int i = 0; i < N; i++) check($sformatf("r1_word%0d", i), word(i), 32'h8001_1234);
    check("r1_len", log_cmd.size(), 32'd24);
    for (int e = 0; e < N; e++) chk_seq(e * 8);
    tick(5);
    check("r1_done_pulses", rd_cnt, 32'd1);

    // WADDR NACK on entry 1, then recovery
    do_reset();
    nack_entry = 1;
    enable = 1'b1;
    wait_round();
    check("nack_len", log_cmd.size(), 32'd19);
    check("nack_op8",  {30'd0, log_cmd[8][10:9]}, 32'd0);
    check("nack_op9",  {21'd0, log_cmd[9]},  {21'd0, 2'b10, 8'h80, 1'b0});
    check("nack_op10", {30'd0, log_cmd[10][10:9]}, 32'd1);
    chk_seq(11);
    check("nack_w0", word(0), 32'h8001_1234);
    check("nack_w1", word(1), 32'h4100_0000);
    check("nack_w2", word(2), 32'h8001_1234);
    nack_entry = -1;
    wait_round();
    check("recov_w0", word(0), 32'h8002_1234);
    check("recov_w1", word(1), 32'h8101_1234);
    check("recov_w2", word(2), 32'h8002_1234);

    // RLSB never answered: STOP valid 50 cycles after acceptance, accepted on the next edge
    do_reset();
    noresp = 1'b1;
    enable = 1'b1;
    wait_round();
    noresp = 1'b0;
    check("to_rlsb_op", {21'd0, log_cmd[5]}, {21'd0, 2'b11, 8'h00, 1'b0});
    check("to_stop_op", {30'd0, log_cmd[6][10:9]}, 32'd1);
    check("to_delay", log_cyc[6] - log_cyc[5], 32'd51);
    check("to_w0", word(0), 32'h4100_0000);
    check("to_w2", word(2), 32'h4100_0000);

    // ready held low 20 cycles on WCMD of entry 0
    do_reset();
    hold_req = 1'b1;
    enable = 1'b1;
    wait_round();
    hold_req = 1'b0;
    check("hold_len", log_cmd.size(), 32'd24);
    for (int e = 0; e < N; e++) chk_seq(e * 8);
    check("hold_w0", word(0), 32'h8001_1234);

    // enable dropped mid-round
    do_reset();
    enable = 1'b1;
    tick(4);
    enable = 1'b0;
    wait_round();
    n = log_cmd.size();
    tick(300);
    check("en_idle_cmds", log_cmd.size(), n);
    check("en_idle_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    tick();
    check("en_restart_busy", {31'd0, busy}, 32'd1);
    wait_round();
    check("en_r2_w2", word(2), 32'h8002_1234);

    // reset during the RMSB command of entry 1
    do_reset();
    enable = 1'b1;
    seen = 0;
    n = 0;
    while (seen < 2 && n < 2000) begin
      tick();
      n++;
      if (i2c_cmd_valid && i2c_cmd_op == 2'b11 && i2c_cmd_nack) seen++;
    end
    check("rmsb_found", seen, 32'd2);
    reset = 1'b1;
    enable = 1'b0;
    n = log_cmd.size();
    tick();
    check("mrst_w0", word(0), 32'h0);
    check("mrst_outs", {28'd0, i2c_cmd_valid, busy, round_done, i2c_cmd_op != 2'b00}, 32'h0);
    tick(3);
    check("mrst_no_stop", log_cmd.size(), n);
    reset = 1'b0;
    enable = 1'b1;
    wait_round();
    chk_seq(n);
    for (int i = 0; i < N; i++) check($sformatf("mrst_word%0d", i), word(i), 32'h8001_1234);

    // update-count wrap and error-count saturation
    do_reset();
    enable = 1'b1;
    repeat (255) wait_round();
    check("upd_255", word(0), 32'h80FF_1234);
    wait_round();
    check("upd_wrap", word(0), 32'h8000_1234);
    nack_all = 1'b1;
    repeat (62) wait_round();
    check("err_62", word(0), 32'h7E00_1234);
    wait_round();
    check("err_63", word(1), 32'h7F00_1234);
    wait_round();
    check("err_sat", word(2), 32'h7F00_1234);
    nack_all = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
